// File: rtl/paint_pkg.sv
// Shared types for the paint/camera compositor: controller states, view mode
// and symbolic overlay colours (channel levels resolved to OUT_BITS in the top).
package paint_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_RUN,
    ST_HOLD
  } state_e;

  typedef enum logic {
    MODE_PAINT = 1'b0,
    MODE_CAM   = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    LVL_ZERO,
    LVL_HALF,
    LVL_FULL
  } level_e;

  typedef struct packed {
    level_e r;
    level_e g;
    level_e b;
  } colour_t;

  localparam colour_t RED      = '{r: LVL_FULL, g: LVL_ZERO, b: LVL_ZERO};
  localparam colour_t BLUE     = '{r: LVL_ZERO, g: LVL_ZERO, b: LVL_FULL};
  localparam colour_t MARKER   = '{r: LVL_FULL, g: LVL_HALF, b: LVL_HALF};
  localparam colour_t CAM_HIGH = '{r: LVL_HALF, g: LVL_FULL, b: LVL_HALF};

endpackage

// File: rtl/cursor_overlay.sv
// Combinational crosshair hit test against the cursor position; the radius
// limits the arm length in paint mode, camera mode uses the full lines.
module cursor_overlay (
  input  logic [10:0] i_col,
  input  logic [10:0] i_row,
  input  logic [10:0] i_cursor_x,
  input  logic [10:0] i_cursor_y,
  input  logic [5:0]  i_radius,
  output logic        o_col_eq,
  output logic        o_row_eq,
  output logic        o_cross
);

  logic [11:0] w_dx, w_dy, w_adx, w_ady;

  assign w_dx  = {1'b0, i_col} - {1'b0, i_cursor_x};
  assign w_dy  = {1'b0, i_row} - {1'b0, i_cursor_y};
  assign w_adx = w_dx[11] ? -w_dx : w_dx;
  assign w_ady = w_dy[11] ? -w_dy : w_dy;

  assign o_col_eq = (i_col == i_cursor_x);
  assign o_row_eq = (i_row == i_cursor_y);
  assign o_cross  = (o_col_eq && (w_ady <= 12'(i_radius))) ||
                    (o_row_eq && (w_adx <= 12'(i_radius)));

endmodule

// File: rtl/paint_compositor.sv
// Frame-memory clear/paint controller and VGA pixel compositor.
// Optional COMPOSITOR_CAM_THRESH_EN: bright camera pixels shown in a highlight colour.
module paint_compositor
  import paint_pkg::*;
#(
  parameter int CH_BITS  = 3,
  parameter int OUT_BITS = 8,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_OFFSET = 145,
  parameter int V_OFFSET = 36,
  parameter int R_MIN    = 6,
  parameter int R_STEP   = 2,
  parameter int R_MAX    = 20,
  parameter int MIRROR_X = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  mode_cam,
  input  logic                  mode_color,
  input  logic                  clear_req,
  input  logic                  radius_key_n,
  input  logic [3*CH_BITS-1:0]  pen_color,
  input  logic                  ativo,
  input  logic [10:0]           x_vga,
  input  logic [10:0]           y_vga,
  input  logic [10:0]           cursor_x,
  input  logic [10:0]           cursor_y,
  input  logic                  finger_valid,
  input  logic                  cam_we,
  input  logic [19:0]           cam_addr,
  input  logic [7:0]            cam_data,
  input  logic                  cursor_we,
  input  logic [19:0]           cursor_addr,
  input  logic [3*CH_BITS-1:0]  mem_rdata,
  output logic                  mem_re,
  output logic [19:0]           mem_raddr,
  output logic                  mem_we,
  output logic [19:0]           mem_waddr,
  output logic [3*CH_BITS-1:0]  mem_wdata,
  output logic [OUT_BITS-1:0]   vga_r,
  output logic [OUT_BITS-1:0]   vga_g,
  output logic [OUT_BITS-1:0]   vga_b,
  output logic [5:0]            radius,
  output logic                  busy
);

  localparam int PW = 3 * CH_BITS;
  localparam int MB = (PW < 8) ? PW : 8;
  localparam logic [19:0] LAST_ADDR = 20'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [OUT_BITS-1:0] MAXV  = '1;
  localparam logic [OUT_BITS-1:0] HALFV = MAXV >> 1;

  state_e                  r_state;
  logic                    r_busy, r_cam_d, r_mem_re, r_mem_we;
  logic [19:0]             r_clr_addr, r_mem_raddr, r_mem_waddr;
  logic [PW-1:0]           r_mem_wdata;
  logic [5:0]              r_radius;
  logic [3*OUT_BITS-1:0]   r_rgb;

  mode_e                   w_mode;
  logic [10:0]             w_hpos, w_col, w_row;
  logic [19:0]             w_raddr;
  logic [6:0]              w_rad_sum;
  logic [5:0]              w_rad_next;
  logic [7:0]              w_mem8, w_grey8;
  logic [OUT_BITS-1:0]     w_grey;
  logic [3*OUT_BITS-1:0]   w_rgb;
  logic                    w_col_eq, w_row_eq, w_cross, w_clear_go;

  function automatic logic [OUT_BITS-1:0] expand(input logic [CH_BITS-1:0] c);
    return OUT_BITS'(c) << (OUT_BITS - CH_BITS);
  endfunction

  function automatic logic [OUT_BITS-1:0] lvl(input level_e l);
    case (l)
      LVL_FULL: return MAXV;
      LVL_HALF: return HALFV;
      default:  return '0;
    endcase
  endfunction

  function automatic logic [3*OUT_BITS-1:0] const_rgb(input colour_t c);
    return {lvl(c.r), lvl(c.g), lvl(c.b)};
  endfunction

  assign w_mode  = mode_e'(mode_cam);
  assign w_hpos  = x_vga - 11'(H_OFFSET);
  assign w_col   = (MIRROR_X != 0) ? 11'(H_ACTIVE) - w_hpos : w_hpos;
  assign w_row   = y_vga - 11'(V_OFFSET);
  assign w_raddr = 20'(w_row - 11'd1) * 20'(H_ACTIVE) + 20'(w_col);

  assign w_rad_sum  = 7'(r_radius) + 7'(R_STEP);
  assign w_rad_next = (w_rad_sum > 7'(R_MAX)) ? 6'(R_MIN) : w_rad_sum[5:0];
  assign w_clear_go = clear_req || (r_cam_d && !mode_cam);

  cursor_overlay u_overlay (
    .i_col      (w_col),
    .i_row      (w_row),
    .i_cursor_x (cursor_x),
    .i_cursor_y (cursor_y),
    .i_radius   (r_radius),
    .o_col_eq   (w_col_eq),
    .o_row_eq   (w_row_eq),
    .o_cross    (w_cross)
  );

  always_comb begin
    w_mem8 = '0;
    w_mem8[MB-1:0] = mem_rdata[MB-1:0];
    w_grey8 = w_mem8 << 1;
    w_grey  = OUT_BITS'(w_grey8);
    w_rgb   = '0;
    if (ativo) begin
      if (w_mode == MODE_PAINT) begin
        if (mode_color)
          w_rgb = {expand(pen_color[PW-1 -: CH_BITS]),
                   expand(pen_color[2*CH_BITS-1 -: CH_BITS]),
                   expand(pen_color[CH_BITS-1:0])};
        else if (w_cross)
          w_rgb = const_rgb(RED);
        else
          w_rgb = {expand(mem_rdata[PW-1 -: CH_BITS]),
                   expand(mem_rdata[2*CH_BITS-1 -: CH_BITS]),
                   expand(mem_rdata[CH_BITS-1:0])};
      end else begin
        if (finger_valid && (w_col_eq || w_row_eq))
          w_rgb = const_rgb(BLUE);
        else if (!finger_valid && (w_row == 11'(V_ACTIVE / 2 - 1)))
          w_rgb = const_rgb(MARKER);
`ifdef COMPOSITOR_CAM_THRESH_EN
        else if (w_mem8 > 8'd127)
          w_rgb = const_rgb(CAM_HIGH);
`endif
        else
          w_rgb = {3{w_grey}};
      end
    end
  end

  // Clear requests pre-empt every state (including a clear already under way)
  // and suppress the radius step that may arrive in the same cycle.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_state     <= ST_CLEAR;
      r_busy      <= 1'b1;
      r_clr_addr  <= '0;
      r_radius    <= 6'(R_MIN);
      r_cam_d     <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_raddr <= '0;
      r_mem_we    <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
      r_rgb       <= '0;
    end else begin
      r_cam_d     <= mode_cam;
      r_mem_re    <= ativo;
      r_mem_raddr <= w_raddr;
      r_rgb       <= (r_state == ST_CLEAR) ? '0 : w_rgb;
      if (w_clear_go) begin
        r_state    <= ST_CLEAR;
        r_busy     <= 1'b1;
        r_clr_addr <= '0;
        r_mem_we   <= 1'b0;
      end else if (r_state == ST_CLEAR) begin
        r_mem_we    <= 1'b1;
        r_mem_waddr <= r_clr_addr;
        r_mem_wdata <= '0;
        if (r_clr_addr == LAST_ADDR) begin
          r_state <= ST_RUN;
          r_busy  <= 1'b0;
        end else begin
          r_clr_addr <= r_clr_addr + 20'd1;
        end
      end else begin
        if (w_mode == MODE_CAM) begin
          r_mem_we    <= cam_we;
          r_mem_waddr <= cam_addr;
          r_mem_wdata <= PW'(cam_data);
        end else begin
          r_mem_we    <= cursor_we;
          r_mem_waddr <= cursor_addr;
          r_mem_wdata <= pen_color;
        end
        if (r_state == ST_RUN) begin
          if (w_mode == MODE_PAINT && !radius_key_n && !mode_color) begin
            r_radius <= w_rad_next;
            r_state  <= ST_HOLD;
          end
        end else if (radius_key_n) begin
          r_state <= ST_RUN;
        end
      end
    end
  end

  assign mem_re    = r_mem_re;
  assign mem_raddr = r_mem_raddr;
  assign mem_we    = r_mem_we;
  assign mem_waddr = r_mem_waddr;
  assign mem_wdata = r_mem_wdata;
  assign vga_r     = r_rgb[3*OUT_BITS-1 -: OUT_BITS];
  assign vga_g     = r_rgb[2*OUT_BITS-1 -: OUT_BITS];
  assign vga_b     = r_rgb[OUT_BITS-1:0];
  assign radius    = r_radius;
  assign busy      = r_busy;

endmodule

// File: tb/tb_paint_compositor.sv
// Directed bench for paint_compositor with a narrow active area (32x480)
// so full clears stay short; expected values are hand-computed constants.
module tb_paint_compositor;

  localparam int H_ACT = 32;
  localparam int V_ACT = 480;
  localparam int PIX   = H_ACT * V_ACT;

  logic        clk = 1'b0;
  logic        reset_n, mode_cam, mode_color, clear_req, radius_key_n;
  logic [8:0]  pen_color, mem_rdata;
  logic        ativo, finger_valid, cam_we, cursor_we;
  logic [10:0] x_vga, y_vga, cursor_x, cursor_y;
  logic [19:0] cam_addr, cursor_addr;
  logic [7:0]  cam_data;
  logic        mem_re, mem_we, busy;
  logic [19:0] mem_raddr, mem_waddr;
  logic [8:0]  mem_wdata;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic [5:0]  radius;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  paint_compositor #(
    .H_ACTIVE(H_ACT),
    .V_ACTIVE(V_ACT)
  ) dut (
    .CLOCK_50     (clk),
    .reset_n      (reset_n),
    .mode_cam     (mode_cam),
    .mode_color   (mode_color),
    .clear_req    (clear_req),
    .radius_key_n (radius_key_n),
    .pen_color    (pen_color),
    .ativo        (ativo),
    .x_vga        (x_vga),
    .y_vga        (y_vga),
    .cursor_x     (cursor_x),
    .cursor_y     (cursor_y),
    .finger_valid (finger_valid),
    .cam_we       (cam_we),
    .cam_addr     (cam_addr),
    .cam_data     (cam_data),
    .cursor_we    (cursor_we),
    .cursor_addr  (cursor_addr),
    .mem_rdata    (mem_rdata),
    .mem_re       (mem_re),
    .mem_raddr    (mem_raddr),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .radius       (radius),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_rgb(input string tag, input int r, input int g, input int b);
    check({tag, ".r"}, 32'(vga_r), 32'(r));
    check({tag, ".g"}, 32'(vga_g), 32'(g));
    check({tag, ".b"}, 32'(vga_b), 32'(b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mirrored display: col = H_ACT - (x - 145), so x = 145 + H_ACT - col.
  task automatic set_pix(input int col, input int row);
    x_vga = 11'(145 + H_ACT - col);
    y_vga = 11'(36 + row);
  endtask

  task automatic wait_clear(output int cnt, output int first, output int last, output int nz);
    cnt = 0; first = -1; last = -1; nz = 0;
    for (int i = 0; i < PIX + 100; i++) begin
      tick();
      if (mem_we) begin
        if (cnt == 0) first = int'(mem_waddr);
        last = int'(mem_waddr);
        cnt++;
        if (mem_wdata != '0) nz++;
      end
      if (!busy) break;
    end
  endtask

  initial begin
    int cnt, first, last, nz;
    int exp_r[8] = '{8, 10, 12, 14, 16, 18, 20, 6};

    reset_n = 1'b0; mode_cam = 1'b0; mode_color = 1'b1; clear_req = 1'b0;
    radius_key_n = 1'b1; pen_color = 9'h1FF; mem_rdata = '0; ativo = 1'b1;
    finger_valid = 1'b0; cam_we = 1'b0; cursor_we = 1'b1; cam_addr = '0;
    cam_data = '0; cursor_addr = 20'd99; cursor_x = 11'd1000; cursor_y = 11'd1000;
    set_pix(5, 11);
    repeat (3) tick();
    check("rst_busy", 32'(busy), 1);
    check("rst_radius", 32'(radius), 6);
    check_rgb("rst_vga", 0, 0, 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_raddr", 32'(mem_raddr), 0);

    reset_n = 1'b1; mode_color = 1'b0; cursor_we = 1'b0;
    wait_clear(cnt, first, last, nz);
    check("clr_count", 32'(cnt), PIX);
    check("clr_first", 32'(first), 0);
    check("clr_last", 32'(last), PIX - 1);
    check("clr_nonzero", 32'(nz), 0);
    check("clr_done", 32'(busy), 0);
    tick();
    check("run_no_write", 32'(mem_we), 0);

    for (int i = 0; i < 8; i++) begin
      radius_key_n = 1'b0;
      repeat (3) tick();
      radius_key_n = 1'b1;
      repeat (2) tick();
      check($sformatf("radius_%0d", i), 32'(radius), 32'(exp_r[i]));
    end

    mem_rdata = 9'b111_000_101;
    set_pix(5, 11);
    tick();
    check_rgb("paint_mem", 224, 0, 160);
    check("raddr", 32'(mem_raddr), 325);
    check("mem_re", 32'(mem_re), 1);
    mode_color = 1'b1; pen_color = 9'b010_110_001;
    tick();
    check_rgb("preview", 64, 192, 32);
    mode_color = 1'b0; ativo = 1'b0;
    tick();
    check_rgb("blank", 0, 0, 0);
    check("mem_re_off", 32'(mem_re), 0);
    ativo = 1'b1;

    cursor_x = 11'd100; cursor_y = 11'd50;
    set_pix(100, 56); tick(); check_rgb("cross_v_edge", 255, 0, 0);
    set_pix(100, 57); tick(); check_rgb("cross_v_out", 224, 0, 160);
    set_pix(106, 50); tick(); check_rgb("cross_h_edge", 255, 0, 0);
    set_pix(107, 50); tick(); check_rgb("cross_h_out", 224, 0, 160);
    set_pix(94, 50);  tick(); check_rgb("cross_h_left", 255, 0, 0);

    cursor_we = 1'b1; cursor_addr = 20'd777; pen_color = 9'h1A5;
    tick();
    check("pwr_we", 32'(mem_we), 1);
    check("pwr_addr", 32'(mem_waddr), 777);
    check("pwr_data", 32'(mem_wdata), 32'h1A5);

    mode_cam = 1'b1; finger_valid = 1'b0; mem_rdata = 9'd200; cursor_we = 1'b0;
    set_pix(20, 239); tick(); check_rgb("cam_marker", 255, 127, 127);
    set_pix(20, 100); tick();
`ifdef COMPOSITOR_CAM_THRESH_EN
    check_rgb("cam_bright", 127, 255, 127);
`else
    check_rgb("cam_bright", 144, 144, 144);
`endif
    mem_rdata = 9'd50;
    tick(); check_rgb("cam_grey", 100, 100, 100);
    finger_valid = 1'b1;
    set_pix(100, 100); tick(); check_rgb("cam_finger_col", 0, 0, 255);
    set_pix(20, 50);   tick(); check_rgb("cam_finger_row", 0, 0, 255);
    set_pix(20, 239);  tick(); check_rgb("cam_no_marker", 100, 100, 100);

    cam_we = 1'b1; cam_addr = 20'd1234; cam_data = 8'hAB; cursor_we = 1'b1;
    tick();
    check("cwr_we", 32'(mem_we), 1);
    check("cwr_addr", 32'(mem_waddr), 1234);
    check("cwr_data", 32'(mem_wdata), 32'hAB);
    cam_we = 1'b0; cursor_we = 1'b0; finger_valid = 1'b0;

    mem_rdata = 9'b111_000_101; set_pix(5, 11);
    mode_cam = 1'b0; radius_key_n = 1'b0; clear_req = 1'b1;
    tick();
    check("race_busy", 32'(busy), 1);
    check("race_radius", 32'(radius), 6);
    check("race_we", 32'(mem_we), 0);
    radius_key_n = 1'b1; clear_req = 1'b0;
    repeat (4) tick();
    check("mid_we", 32'(mem_we), 1);
    check("mid_addr", 32'(mem_waddr), 3);
    check_rgb("mid_vga", 0, 0, 0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_clear(cnt, first, last, nz);
    check("reclr_count", 32'(cnt), PIX);
    check("reclr_first", 32'(first), 0);
    check("reclr_last", 32'(last), PIX - 1);
    check("reclr_done", 32'(busy), 0);
    check("reclr_radius", 32'(radius), 6);

    radius_key_n = 1'b0; tick(); tick();
    radius_key_n = 1'b1; tick();
    check("post_radius", 32'(radius), 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/paint_compositor.md
PAINT_COMPOSITOR -- requirements
Module: paint_compositor

Interface
REQ-001 SHALL have parameter CH_BITS, default 3: frame-memory bits per colour channel.
REQ-002 SHALL have parameter OUT_BITS, default 8: VGA bits per channel; OUT_BITS >= CH_BITS.
REQ-003 SHALL have parameters H_ACTIVE=640, V_ACTIVE=480, H_OFFSET=145, V_OFFSET=36: active area and VGA counter offsets.
REQ-004 SHALL have parameters R_MIN=6, R_STEP=2, R_MAX=20: brush radius cycle.
REQ-005 SHALL have parameter MIRROR_X, default 1: horizontally mirror the displayed image.
REQ-006 SHALL have port CLOCK_50, input, 1 bit: the only clock.
REQ-007 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have input ports: mode_cam (1 = camera view, 0 = paint), mode_color (1 = colour preview), clear_req (1 bit each).
REQ-009 SHALL have input radius_key_n, 1 bit: active-low radius button, already debounced.
REQ-010 SHALL have input pen_color, 3*CH_BITS bits, ordered {R,G,B}.
REQ-011 SHALL have inputs ativo (1 bit), x_vga and y_vga (11 bits each): VGA timing.
REQ-012 SHALL have inputs cursor_x and cursor_y (11 bits each, active-area coordinates) and finger_valid (1 bit).
REQ-013 SHALL have inputs cam_we (1), cam_addr (20), cam_data (8), cursor_we (1), cursor_addr (20), mem_rdata (3*CH_BITS).
REQ-014 SHALL have outputs mem_re (1), mem_raddr (20), mem_we (1), mem_waddr (20), mem_wdata (3*CH_BITS).
REQ-015 SHALL have outputs vga_r, vga_g, vga_b (OUT_BITS each), radius (6), busy (1).

Function
REQ-016 SHALL implement states CLEAR, RUN and HOLD.
REQ-017 CLEAR: one write per cycle of 0 to addresses 0..H_ACTIVE*V_ACTIVE-1; busy=1; VGA outputs 0; cam and cursor write ports ignored; after the last address, go to RUN next cycle.
REQ-018 CLEAR SHALL be entered on reset, on clear_req=1 in any state, and on a mode_cam 1->0 transition; re-entry mid-clear restarts at address 0.
REQ-019 RUN, paint mode: radius_key_n=0 and mode_color=0 -> radius += R_STEP, wrapping to R_MIN when the result exceeds R_MAX; go to HOLD.
REQ-020 HOLD: no radius change; return to RUN when radius_key_n=1; pixel and write paths behave as in RUN.
REQ-021 If clear_req and a radius press occur in the same cycle, clear_req SHALL win and radius SHALL be unchanged.
REQ-022 mem_raddr SHALL be registered (1 cycle) and equal (y_vga-V_OFFSET-1)*H_ACTIVE + col.
REQ-023 col SHALL be H_ACTIVE-(x_vga-H_OFFSET) when MIRROR_X=1, else x_vga-H_OFFSET; mem_re SHALL be ativo.
REQ-024 VGA outputs SHALL be registered; channel expansion SHALL be a left shift by OUT_BITS-CH_BITS.
REQ-025 Paint priority: ativo=0 -> 0; mode_color -> expanded pen_color; crosshair -> red full-scale, G=B=0; otherwise expanded mem_rdata.
REQ-026 Paint crosshair: (col==cursor_x and |row-cursor_y|<=radius) or (row==cursor_y and |col-cursor_x|<=radius), where row = y_vga-V_OFFSET.
REQ-027 Camera priority: ativo=0 -> 0; finger_valid and (col==cursor_x or row==cursor_y) -> blue full-scale; !finger_valid and row==V_ACTIVE/2-1 -> (max, max/2, max/2); otherwise grey of mem_rdata[7:0]<<1, truncated.
REQ-028 Write mux, registered 1 cycle outside CLEAR: camera mode -> cam_we/cam_addr/cam_data zero-extended; paint mode -> cursor_we/cursor_addr/pen_color.

Reset
REQ-029 reset_n=0 at a clock edge -> state CLEAR at address 0, radius=R_MIN, busy=1, VGA outputs 0, mem_we=0, mem_raddr=0.

Configuration
REQ-030 With COMPOSITOR_CAM_THRESH_EN defined, camera pixels with mem_rdata[7:0]>127 SHALL display as (max/2, max, max/2); without it, no threshold applies and all camera pixels display as grey.

Structure
REQ-031 Package paint_pkg SHALL hold the state enum, mode encoding and the colour constants RED, BLUE and MARKER.
REQ-032 Crosshair hit detection SHALL be sub-module cursor_overlay (combinational, shared by both modes).

Verification
REQ-033 Reset, then run H_ACTIVE*V_ACTIVE cycles -> 307200 writes of 0, busy falls, state RUN.
REQ-034 Press radius_key_n 8 times from reset -> radius sequence 8,10,12,14,16,18,20,6; holding the key gives exactly one step.
REQ-035 Paint mode, mem_rdata=9'b111_000_101, no crosshair -> next cycle vga = (224,0,160).
REQ-036 cursor=(100,50), radius 6, pixel at col 100, row 56 -> red; row 57 -> memory colour.
REQ-037 Camera mode, finger_valid=0, row 239 -> (255,127,127); mem_rdata=200 -> (127,255,127) with the macro, (144,144,144) without it.
REQ-038 mode_cam 1->0 while a radius press and clear_req arrive together -> CLEAR restarts at address 0, radius unchanged.
